// File: rtl/player_ctrl.sv
// Player plane controller: per-button synchroniser and debouncer, once-per-frame
// clamped movement, and a frame-based cooldown FSM for bullet-spawn pulses.
module player_ctrl #(
   parameter int H_RES           = 800,
   parameter int V_RES           = 600,
   parameter int PLANE_W         = 64,
   parameter int PLANE_H         = 64,
   parameter int STEP            = 4,
   parameter int DEBOUNCE_CYCLES = 400000,
   parameter int FIRE_COOLDOWN   = 8,
   parameter int X_INIT          = 368,
   parameter int Y_INIT          = 520
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick_i,
   input  logic       enable_i,
   input  logic       btn_up_i,
   input  logic       btn_down_i,
   input  logic       btn_left_i,
   input  logic       btn_right_i,
   input  logic       btn_fire_i,
   output logic [9:0] plane_x_o,
   output logic [9:0] plane_y_o,
   output logic       fire_o,
   output logic [9:0] fire_x_o,
   output logic [9:0] fire_y_o
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CD_W = $clog2(FIRE_COOLDOWN + 1);
   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CD_W-1:0]   CD_LOAD  = CD_W'(FIRE_COOLDOWN - 1);
   localparam logic signed [11:0] X_MAX   = 12'(H_RES - PLANE_W);
   localparam logic signed [11:0] Y_MAX   = 12'(V_RES - PLANE_H);
   localparam logic signed [11:0] STEP_S  = 12'(STEP);
   localparam logic [9:0]        FIRE_OFS = 10'(PLANE_W / 2 - 1);
   localparam logic [9:0]        X_RST    = 10'(X_INIT);
   localparam logic [9:0]        Y_RST    = 10'(Y_INIT);

   // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 fire
   localparam int B_UP = 0, B_DN = 1, B_LT = 2, B_RT = 3, B_FI = 4;

   typedef enum logic [0:0] {
      READY   = 1'b0,
      COOLING = 1'b1
   } fire_state_e;

   logic [4:0]      btn_raw;
   logic [4:0]      sync1_q, sync1_d, sync2_q, sync2_d;
   logic [4:0]      btn_lvl_q, btn_lvl_d;
   logic [DB_W-1:0] db_cnt_q [5];
   logic [DB_W-1:0] db_cnt_d [5];

   logic [9:0]      x_q, x_d, y_q, y_d;
   logic signed [11:0] dx, dy, x_sum, y_sum;

   fire_state_e     state_q, state_d;
   logic [CD_W-1:0] cd_q, cd_d;
   logic            fire_q, fire_d;
   logic [9:0]      fire_x_q, fire_x_d, fire_y_q, fire_y_d;
   logic            step_en;

   assign btn_raw = {btn_fire_i, btn_right_i, btn_left_i, btn_down_i, btn_up_i};
   assign step_en = frame_tick_i & enable_i;

   // Synchronise and debounce every button
   always_comb begin
      sync1_d   = btn_raw;
      sync2_d   = sync1_q;
      btn_lvl_d = btn_lvl_q;
      for (int i = 0; i < 5; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != btn_lvl_q[i]) begin
            if (db_cnt_q[i] == DB_MAX) begin
               btn_lvl_d[i] = ~btn_lvl_q[i];
               db_cnt_d[i]  = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end
   end

   // Per-frame movement; opposing buttons on an axis cancel, result clamped to screen
   always_comb begin
      if (btn_lvl_q[B_RT] && !btn_lvl_q[B_LT]) begin
         dx = STEP_S;
      end else if (btn_lvl_q[B_LT] && !btn_lvl_q[B_RT]) begin
         dx = -STEP_S;
      end else begin
         dx = 12'sd0;
      end
      if (btn_lvl_q[B_DN] && !btn_lvl_q[B_UP]) begin
         dy = STEP_S;
      end else if (btn_lvl_q[B_UP] && !btn_lvl_q[B_DN]) begin
         dy = -STEP_S;
      end else begin
         dy = 12'sd0;
      end
      x_sum = $signed({2'b00, x_q}) + dx;
      y_sum = $signed({2'b00, y_q}) + dy;
      x_d   = x_q;
      y_d   = y_q;
      if (step_en) begin
         if (x_sum < 12'sd0) begin
            x_d = 10'd0;
         end else if (x_sum > X_MAX) begin
            x_d = X_MAX[9:0];
         end else begin
            x_d = x_sum[9:0];
         end
         if (y_sum < 12'sd0) begin
            y_d = 10'd0;
         end else if (y_sum > Y_MAX) begin
            y_d = Y_MAX[9:0];
         end else begin
            y_d = y_sum[9:0];
         end
      end else begin
         x_d = x_q;
         y_d = y_q;
      end
   end

   // Fire FSM: shot position uses the pre-move position of the same tick
   always_comb begin
      state_d  = state_q;
      cd_d     = cd_q;
      fire_d   = 1'b0;
      fire_x_d = fire_x_q;
      fire_y_d = fire_y_q;
      if (step_en) begin
         case (state_q)
            READY: begin
               if (btn_lvl_q[B_FI]) begin
                  fire_d   = 1'b1;
                  fire_x_d = x_q + FIRE_OFS;
                  fire_y_d = y_q;
                  cd_d     = CD_LOAD;
                  if (CD_LOAD == '0) begin
                     state_d = READY;
                  end else begin
                     state_d = COOLING;
                  end
               end else begin
                  state_d = READY;
               end
            end
            COOLING: begin
               cd_d = cd_q - CD_W'(1);
               if (cd_d == '0) begin
                  state_d = READY;
               end else begin
                  state_d = COOLING;
               end
            end
            default: begin
               state_d = READY;
               cd_d    = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 5'd0;
         sync2_q   <= 5'd0;
         btn_lvl_q <= 5'd0;
         for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
         x_q       <= X_RST;
         y_q       <= Y_RST;
         state_q   <= READY;
         cd_q      <= '0;
         fire_q    <= 1'b0;
         fire_x_q  <= 10'd0;
         fire_y_q  <= 10'd0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         btn_lvl_q <= btn_lvl_d;
         for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
         x_q       <= x_d;
         y_q       <= y_d;
         state_q   <= state_d;
         cd_q      <= cd_d;
         fire_q    <= fire_d;
         fire_x_q  <= fire_x_d;
         fire_y_q  <= fire_y_d;
      end
   end

   assign plane_x_o = x_q;
   assign plane_y_o = y_q;
   assign fire_o    = fire_q;
   assign fire_x_o  = fire_x_q;
   assign fire_y_o  = fire_y_q;

endmodule
